// File: rtl/sample_stream_reader_pkg.sv
// Shared types and constants for the sample stream reader and its output buffer.
package sample_stream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned BUF_DEPTH  = 2;
  localparam int unsigned CNT_W      = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/sample_stream_reader_if.sv
// Valid/ready sample stream from the reader (master) to the playback consumer (slave).
interface sample_stream_reader_if #(
  parameter int unsigned DATA_W = 16
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/sample_skid_fifo.sv
// Two-entry registered FIFO; head is a register so the stream output comes straight off a flop.
module sample_skid_fifo
  import sample_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [CNT_W-1:0]  o_count,
  output logic [DATA_W-1:0] o_head,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop;
  logic              w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // A push into a full buffer is only legal when a pop frees a slot in the same cycle.
  assign w_push = i_push && ((r_count != CNT_W'(BUF_DEPTH)) || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == '0) r_head <= i_data;
          else               r_tail <= i_data;
          r_count <= r_count + CNT_W'(1);
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - CNT_W'(1);
        end
        2'b11: begin
          if (r_count == CNT_W'(1)) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;
  assign o_valid = (r_count != '0);

endmodule

// File: rtl/sample_stream_reader.sv
// Streams a contiguous block of samples out of a 1-cycle-latency RAM over valid/ready.
// Optional SAMPLE_STREAM_LOOP_EN adds i_loop for endless replay of the block until abort.
module sample_stream_reader
  import sample_stream_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = ADDR_W + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [ADDR_W-1:0]       i_base_addr,
  input  logic [LEN_W-1:0]        i_length,
`ifdef SAMPLE_STREAM_LOOP_EN
  input  logic                    i_loop,
`endif
  input  logic                    i_abort,
  output logic                    o_mem_rd_en,
  output logic [ADDR_W-1:0]       o_mem_addr,
  input  logic [DATA_W-1:0]       i_mem_dout,
  sample_stream_reader_if.master  if_out,
  output logic                    o_busy,
  output logic                    o_done
);

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_length;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_emitted;
  logic              r_inflight;

  logic              w_accept;
  logic              w_loop;
  logic              w_rd_en;
  logic              w_pop;
  logic              w_push;
  logic              w_flush;
  logic              w_last_issue;
  logic              w_last_emit;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [DATA_W-1:0] w_fifo_head;
  logic              w_fifo_valid;
  logic [CNT_W:0]    w_used;

`ifdef SAMPLE_STREAM_LOOP_EN
  logic r_loop;

  always_ff @(posedge i_clk) begin
    if (i_rst)         r_loop <= 1'b0;
    else if (w_accept) r_loop <= i_loop;
  end

  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_accept = (r_state == StIdle) && i_start && !i_abort;
  assign w_pop    = w_fifo_valid && if_out.out_ready;
  assign w_flush  = i_abort && ((r_state == StRun) || (r_state == StDrain));
  // Data arriving for a read issued before an abort is dropped by the flush.
  assign w_push   = r_inflight && !w_flush;

  // Slots committed after this cycle's pop; the in-flight read always owns one.
  assign w_used = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};

  assign w_rd_en = (r_state == StRun) && !i_abort && (r_issued != r_length) &&
                   (w_used < (CNT_W + 1)'(BUF_DEPTH));

  assign w_last_issue = ((r_issued + LEN_W'(1)) == r_length);
  assign w_last_emit  = ((r_emitted + LEN_W'(1)) == r_length);

  assign o_mem_rd_en = w_rd_en;
  assign o_mem_addr  = w_rd_en ? (r_base + r_issued[ADDR_W-1:0]) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_base     <= '0;
      r_length   <= '0;
      r_issued   <= '0;
      r_emitted  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_rd_en;
      if (w_accept) begin
        r_base    <= i_base_addr;
        r_length  <= i_length;
        r_issued  <= '0;
        r_emitted <= '0;
      end else begin
        if (w_rd_en) r_issued <= (w_last_issue && w_loop) ? '0 : r_issued + LEN_W'(1);
        if (w_pop)   r_emitted <= r_emitted + LEN_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = (i_length == '0) ? StDone : StRun;
      end
      StRun: begin
        o_busy = 1'b1;
        if (i_abort)                                  w_state_next = StDone;
        else if (w_rd_en && w_last_issue && !w_loop) w_state_next = StDrain;
      end
      StDrain: begin
        o_busy = 1'b1;
        if (i_abort)                  w_state_next = StDone;
        else if (w_pop && w_last_emit) w_state_next = StDone;
      end
      StDone: begin
        o_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  sample_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (i_mem_dout),
    .i_pop   (w_pop),
    .o_count (w_fifo_count),
    .o_head  (w_fifo_head),
    .o_valid (w_fifo_valid)
  );

  assign if_out.out_valid = w_fifo_valid;
  assign if_out.out_data  = w_fifo_head;

endmodule

// File: tb/tb_sample_stream_reader.sv
// Self-checking bench for sample_stream_reader: RAM model, stream monitor and queue-based reference.
module tb_sample_stream_reader;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          abort;
  logic          rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout = '0;
  logic          busy;
  logic          done;
`ifdef SAMPLE_STREAM_LOOP_EN
  logic          loop_en;
`endif

  sample_stream_reader_if #(.DATA_W(DW)) sif ();

  sample_stream_reader #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .LEN_W  (LW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_length    (length),
`ifdef SAMPLE_STREAM_LOOP_EN
    .i_loop      (loop_en),
`endif
    .i_abort     (abort),
    .o_mem_rd_en (rd_en),
    .o_mem_addr  (mem_addr),
    .i_mem_dout  (mem_dout),
    .if_out      (sif),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:65535];

  always @(posedge clk) begin
    if (rd_en) mem_dout <= mem[mem_addr];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0, t0 = 0, first_rd, first_val, done_at, abort_cyc;
  int rd_cnt, hs_cnt, done_cnt, late_rd;
  bit busy_seen, stab_en = 1'b0;
  logic          p_valid = 1'b0, p_ready = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic [DW-1:0] got_q[$], exp_q[$];
  logic [AW-1:0] got_addr[$], exp_addr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observes the DUT every cycle; checks stall stability and the two-slot budget when enabled.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (start && !busy && !abort) t0 = cyc;
      if (abort && abort_cyc < 0) abort_cyc = cyc;
      if (rd_en) begin
        rd_cnt++;
        got_addr.push_back(mem_addr);
        if (first_rd < 0) first_rd = cyc - t0;
        if (abort_cyc >= 0 && cyc > abort_cyc) late_rd++;
      end
      if (sif.out_valid && first_val < 0) first_val = cyc - t0;
      if (sif.out_valid && sif.out_ready) begin
        got_q.push_back(sif.out_data);
        hs_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc - t0;
      end
      if (busy) busy_seen = 1'b1;
      if (stab_en) begin
        if (p_valid && !p_ready)
          chk("stall_hold", 32'({sif.out_valid, sif.out_data}), 32'({1'b1, p_data}));
        chk("outstanding_le2", 32'((rd_cnt - hs_cnt) <= 2), 32'd1);
      end
    end
    p_valid = sif.out_valid;
    p_ready = sif.out_ready;
    p_data  = sif.out_data;
  end

  task automatic clear_mon();
    got_q.delete();
    got_addr.delete();
    rd_cnt = 0; hs_cnt = 0; done_cnt = 0; late_rd = 0;
    first_rd = -1; first_val = -1; done_at = -1; abort_cyc = -1;
    busy_seen = 1'b0;
  endtask

  task automatic start_xfer(input logic [AW-1:0] base, input logic [LW-1:0] len);
    logic [AW-1:0] a;
    clear_mon();
    exp_q.delete();
    exp_addr.delete();
    for (int k = 0; k < int'(len); k++) begin
      a = base + AW'(k);
      exp_addr.push_back(a);
      exp_q.push_back(mem[a]);
    end
    start = 1'b1; base_addr = base; length = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int pct, input int max_cyc);
    int n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      sif.out_ready = ($urandom_range(0, 99) < pct);
      tick();
      n++;
    end
    chk("done_seen", 32'(done_cnt != 0), 32'd1);
    sif.out_ready = 1'b1;
    tick();
    tick();
    chk("done_single", 32'(done_cnt), 32'd1);
  endtask

  task automatic cmp_stream(input string tag, input bit with_addr);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      chk({tag, "_data"}, (k < got_q.size()) ? 32'(got_q[k]) : 32'hDEAD_BEEF, 32'(exp_q[k]));
    if (with_addr)
      for (int k = 0; k < exp_addr.size(); k++)
        chk({tag, "_addr"}, (k < got_addr.size()) ? 32'(got_addr[k]) : 32'hDEAD_BEEF,
            32'(exp_addr[k]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] rb;
    for (int i = 0; i < 65536; i++) mem[i] = DW'(32'h1000 + i);
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0;
    sif.out_ready = 1'b1;
`ifdef SAMPLE_STREAM_LOOP_EN
    loop_en = 1'b0;
`endif
    clear_mon();
    tick();
    tick();
    @(negedge clk);
    chk("reset_outputs", 32'({rd_en, mem_addr, sif.out_valid, sif.out_data, busy, done}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic block: timing of first read, first valid and done.
    start_xfer(16'h0010, 17'd8);
    wait_done(100, 50);
    cmp_stream("basic", 1'b1);
    chk("basic_first_rd", 32'(first_rd), 32'd1);
    chk("basic_first_valid", 32'(first_val), 32'd3);
    chk("basic_done_cycle", 32'(done_at), 32'd11);

    // Zero length: immediate done, no reads, never busy.
    start_xfer(16'h0020, 17'd0);
    wait_done(100, 10);
    chk("zero_rd", 32'(rd_cnt), 32'd0);
    chk("zero_done_cycle", 32'(done_at), 32'd1);
    chk("zero_busy", 32'(busy_seen), 32'd0);

    // start together with abort in idle is ignored.
    clear_mon();
    start = 1'b1; abort = 1'b1; base_addr = 16'h0030; length = 17'd4;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (6) tick();
    chk("startabort_rd", 32'(rd_cnt), 32'd0);
    chk("startabort_busy", 32'(busy_seen), 32'd0);
    chk("startabort_done", 32'(done_cnt), 32'd0);

    // Random data with 40% ready, plus a start pulse while busy that must be ignored.
    for (int k = 0; k < 16; k++) mem[16'h0200 + k] = DW'($urandom);
    stab_en = 1'b1;
    start_xfer(16'h0200, 17'd16);
    start = 1'b1; base_addr = 16'hBEEF; length = 17'd3;
    tick();
    start = 1'b0;
    wait_done(40, 2000);
    cmp_stream("bp40", 1'b1);

    // A few random blocks with random backpressure.
    for (int r = 0; r < 3; r++) begin
      int len;
      rb  = AW'($urandom);
      len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) mem[rb + AW'(k)] = DW'($urandom);
      start_xfer(rb, LW'(len));
      wait_done($urandom_range(30, 100), 2000);
      cmp_stream("rand", 1'b1);
    end
    stab_en = 1'b0;

    // Abort coincident with the third handshake of a 10-sample block.
    start_xfer(16'h0300, 17'd10);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid_low", 32'(sif.out_valid), 32'd0);
    chk("abort_done_high", 32'(done), 32'd1);
    repeat (5) tick();
    chk("abort_hs", 32'(hs_cnt), 32'd3);
    chk("abort_late_rd", 32'(late_rd), 32'd0);
    chk("abort_done_once", 32'(done_cnt), 32'd1);
    for (int k = 0; k < 3; k++)
      chk("abort_data", (k < got_q.size()) ? 32'(got_q[k]) : 32'hDEAD_BEEF, 32'(exp_q[k]));

    // Synchronous reset in the middle of a run.
    start_xfer(16'h0400, 17'd10);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_outputs", 32'({rd_en, mem_addr, sif.out_valid, sif.out_data, busy, done}), 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("midrst_no_done", 32'(done_cnt), 32'd0);

    // Address wrap across the top of memory, also shows recovery after reset.
    start_xfer(16'hFFFE, 17'd4);
    wait_done(100, 50);
    cmp_stream("wrap", 1'b1);

`ifdef SAMPLE_STREAM_LOOP_EN
    loop_en = 1'b1;
    start_xfer(16'h0005, 17'd3);
    loop_en = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 12; k++) exp_q.push_back(mem[16'h0005 + AW'(k % 3)]);
    for (int n = 0; n < 100 && hs_cnt < 12; n++) tick();
    chk("loop_no_done", 32'(done_cnt), 32'd0);
    chk("loop_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 12; k++)
      chk("loop_data", (k < got_q.size()) ? 32'(got_q[k]) : 32'hDEAD_BEEF, 32'(exp_q[k]));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int n = 0; n < 10 && done_cnt == 0; n++) tick();
    tick();
    chk("loop_abort_done", 32'(done_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_stream_reader.md
Name: sample_stream_reader

Overview:
- Reads a contiguous block of 16-bit audio samples out of a `memory_writing` RAM instance (synchronous read, 1-cycle latency).
- Streams them to a downstream consumer over a valid/ready interface at up to one sample per clock.
- It is the read-side counterpart of the processor chain that writes processed samples into that memory, used for playback of the pedal output buffer.
- Full throughput is kept under backpressure by a 2-entry output buffer.

Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 16, sample width
- LEN_W, ADDR_W+1, length field width (allows a full 2^ADDR_W sweep)

Ports:
- clk  in  1  single system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first address, latched on accepted start
- length  in  LEN_W  sample count, latched on accepted start
- abort  in  1  stop current transfer
- mem_rd_en  out  1  read strobe to RAM (we held 0 by top level)
- mem_addr  out  ADDR_W  RAM address
- mem_dout  in  DATA_W  RAM read data
- out_data  out  DATA_W  sample
- out_valid  out  1  sample available
- out_ready  in  1  consumer accepts when high with out_valid
- busy  out  1  high in RUN/DRAIN
- done  out  1  one-cycle pulse at end of transfer

Behaviour:
- Reset (also mid-transfer): state IDLE; mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, busy=0, done=0; buffer emptied; in-flight read discarded.
- RAM contract: mem_rd_en=1 with mem_addr=A in cycle N gives mem[A] on mem_dout in cycle N+1. Data is captured into the buffer in N+1 only if a read was issued in N.
- FSM:
  - IDLE: start=1 latches base/length and goes to RUN. If length=0, go to DONE instead (no reads issued).
  - RUN: issue reads while issued<length and (buffer occupancy + in-flight) < 2. After the last read is issued, go to DRAIN.
  - DRAIN: wait until the final sample handshake (out_valid&&out_ready), then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Addressing: address = base_addr + issue_index, modulo 2^ADDR_W. Wraps 0xFFFF to 0x0000 without error.
- Latency with out_ready=1 throughout:
  - start in cycle 0, first mem_rd_en in cycle 1, first out_valid in cycle 3.
  - One sample per cycle thereafter.
  - done is high the cycle after the last handshake.
- Output rules:
  - out_valid and out_data are registered from buffer head.
  - Once out_valid=1, out_data stays stable until the handshake.
  - Samples are emitted in address order, no drops or duplicates.
- Backpressure: with out_ready=0 the buffer fills to 2 and reads stall. An in-flight read is always guaranteed a slot.
- Simultaneous capture and handshake in the same cycle: occupancy is unchanged.
- start while busy: ignored.
- start and abort together in IDLE: abort wins; start ignored.
- abort in RUN/DRAIN:
  - Reads stop next cycle; buffer flushed; out_valid=0 next cycle.
  - An in-flight read's data is discarded.
  - DONE pulse still issued.
- Counters: issued and emitted counters are LEN_W wide; no overflow at length=2^ADDR_W.

Optional Feature:
- Macro: SAMPLE_STREAM_LOOP_EN.
- Enabled:
  - Adds input port loop (1 bit, latched on start).
  - If latched loop=1, address wraps back to base_addr after length reads and streaming continues indefinitely.
  - No DONE pulse until abort; busy stays 1.
  - length=0 with loop=1 behaves as length=0 (immediate DONE).
- Disabled: port absent; one-shot behaviour only.

Decomposition:
- Package sample_stream_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default ADDR_W/DATA_W constants
  - BUF_DEPTH=2
- One sub-module: sample_skid_fifo, a 2-entry registered FIFO with push, pop, count, head, and a flush input.

Test Plan:
- Preload mem[i]=16'h1000+i; start, base=0x0010, length=8, out_ready=1 -> out_data 0x1010..0x1017 on consecutive cycles; first out_valid at cycle 3; done at cycle 11.
- base=0xFFFE, length=4 -> addresses FFFE, FFFF, 0000, 0001 read; data order matches.
- length=16 with out_ready toggled by pseudo-random 40% duty -> all 16 samples in order; mem_rd_en never pushes occupancy+inflight above 2; out_data stable while stalled.
- length=0 -> no mem_rd_en; done pulse 1 cycle after start; busy never high.
- abort at the 3rd handshake of length=10 -> out_valid=0 next cycle, no further mem_rd_en, done pulse once; rst asserted mid-RUN in a second run -> all outputs 0 next cycle.
- SAMPLE_STREAM_LOOP_EN, loop=1, base=5, length=3 -> stream mem[5],mem[6],mem[7],mem[5],... for 12 samples; abort then gives done.
